// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and constants for the multicycle RV32I control FSM.
// Opcode values follow the RV32I base encoding.
package multicycle_control_fsm_pkg;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OpRType      = 7'b0110011;
    localparam opcode_t OpITypeLogic = 7'b0010011;
    localparam opcode_t OpITypeLoad  = 7'b0000011;
    localparam opcode_t OpSType      = 7'b0100011;
    localparam opcode_t OpBType      = 7'b1100011;
    localparam opcode_t OpJType      = 7'b1101111;

    localparam logic [1:0] AluOpAdd = 2'b00;
    localparam logic [1:0] AluOpSub = 2'b01;
    localparam logic [1:0] AluOpReg = 2'b10;

    typedef enum logic [3:0] {
        StReset,
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StTrap
    } state_t;

    typedef enum logic [1:0] {
        SrcAPc    = 2'b00,
        SrcAOldPc = 2'b01,
        SrcARs1   = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SrcBRs2  = 2'b00,
        SrcBImm  = 2'b01,
        SrcBFour = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ResAluOut    = 2'b00,
        ResReadData  = 2'b01,
        ResAluResult = 2'b10
    } result_src_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the control FSM (master) and the datapath/memory side (slave).
interface multicycle_control_fsm_if
    import multicycle_control_fsm_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) ();

    opcode_t           opcode;
    logic              zero;
    logic              mem_ready;
    logic              mem_req;
    logic              mem_write;
    logic              adr_src;
    logic              ir_write;
    logic              pc_write;
    logic              reg_write;
    alu_src_a_t        alu_src_a;
    alu_src_b_t        alu_src_b;
    logic [1:0]        alu_op;
    result_src_t       result_src;
    logic              illegal_instr;
    logic [CNT_W-1:0]  instret;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        output alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, instret
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        input  alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, instret
    );

endinterface

// File: rtl/multicycle_control_fsm_instret_counter.sv
// Retired-instruction counter; wraps naturally at 2^CNT_W.
module multicycle_control_fsm_instret_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences ALU, memory port, IR and
// register-file writes, traps unsupported opcodes and counts retired instructions.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic                      clk,
    input logic                      reset,
    multicycle_control_fsm_if.master bus
);

    state_t      state_q, state_d;
    logic        illegal_q;
    logic        mem_req, mem_write, adr_src, ir_write, reg_write;
    logic        pc_update, branch, count_en;
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    logic [1:0]  alu_op;
    result_src_t result_src;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StReset;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == StTrap) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        alu_op     = AluOpAdd;
        result_src = ResAluOut;

        unique case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAluResult;
                ir_write   = bus.mem_ready;
                pc_update  = bus.mem_ready;
                if (bus.mem_ready) state_d = StDecode;
            end
            StDecode: begin
                // Branch target is precomputed here so StBeq only has to compare.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                case (bus.opcode)
                    OpRType:              state_d = StExecR;
                    OpITypeLogic:         state_d = StExecI;
                    OpITypeLoad, OpSType: state_d = StMemAdr;
                    OpBType:              state_d = StBeq;
                    OpJType:              state_d = StJal;
                    default:              state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                case (bus.opcode)
                    OpITypeLoad: state_d = StMemRead;
                    OpSType:     state_d = StMemWrite;
                    default:     state_d = StTrap;
                endcase
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = ResReadData;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                alu_op    = AluOpReg;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluOpReg;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBeq: begin
                alu_src_a = SrcARs1;
                alu_op    = AluOpSub;
                branch    = 1'b1;
                state_d   = StFetch;
            end
            StJal: begin
                // rd gets OldPC+4 via the following writeback.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StReset;
        endcase
    end

    // A transition into fetch retires an instruction unless it is the first one after reset.
    assign count_en = (state_d == StFetch) && (state_q != StFetch) && (state_q != StReset);

    multicycle_control_fsm_instret_counter #(
        .CNT_W (CNT_W)
    ) u_instret (
        .clk   (clk),
        .reset (reset),
        .en    (count_en),
        .count (bus.instret)
    );

    assign bus.mem_req       = mem_req;
    assign bus.mem_write     = mem_write;
    assign bus.adr_src       = adr_src;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_update | (branch & bus.zero);
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.result_src    = result_src;
    assign bus.illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: instruction walks, memory stalls, branches,
// trap, counter wrap and asynchronous reset mid-instruction.
module tb_multicycle_control_fsm;

    localparam int unsigned CntW = 4;

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpLoad = 7'b0000011;
    localparam logic [6:0] OpS    = 7'b0100011;
    localparam logic [6:0] OpB    = 7'b1100011;
    localparam logic [6:0] OpJ    = 7'b1101111;
    localparam logic [6:0] OpBad  = 7'b0000000;

    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, a, b, alu_op, result_src}
    localparam logic [13:0] CtlIdle     = 14'b0;
    localparam logic [13:0] CtlFetch    = {6'b100000, 2'b00, 2'b10, 2'b00, 2'b10};
    localparam logic [13:0] CtlFetchRdy = {6'b100110, 2'b00, 2'b10, 2'b00, 2'b10};
    localparam logic [13:0] CtlDecode   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00};
    localparam logic [13:0] CtlMemAdr   = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00};
    localparam logic [13:0] CtlMemRead  = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] CtlMemWb    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b01};
    localparam logic [13:0] CtlMemWrite = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] CtlExecR    = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00};
    localparam logic [13:0] CtlExecI    = {6'b000000, 2'b10, 2'b01, 2'b10, 2'b00};
    localparam logic [13:0] CtlAluWb    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [13:0] CtlBeqTaken = {6'b000010, 2'b10, 2'b00, 2'b01, 2'b00};
    localparam logic [13:0] CtlBeqNot   = {6'b000000, 2'b10, 2'b00, 2'b01, 2'b00};
    localparam logic [13:0] CtlJal      = {6'b000010, 2'b01, 2'b10, 2'b00, 2'b00};

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_W(CntW)) bus ();

    multicycle_control_fsm #(
        .CNT_W (CntW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [13:0] ctl_obs();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [13:0] exp);
        check(tag, {18'b0, ctl_obs()}, {18'b0, exp});
    endtask

    task automatic check_cnt(input string tag, input int unsigned exp);
        check(tag, 32'(bus.instret), exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [6:0] op, input logic z, input logic rdy);
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        #1;
    endtask

    // From a FETCH cycle: complete fetch and decode, leave inputs driven in the next state.
    task automatic start(input logic [6:0] op);
        drive(op, 1'b0, 1'b1);
        check_ctl("fetch_ready", CtlFetchRdy);
        tick();
        drive(op, 1'b0, 1'b1);
        check_ctl("decode", CtlDecode);
        tick();
        drive(op, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(OpBad, 1'b0, 1'b0);
        repeat (3) tick();
        check_ctl("in_reset_ctl", CtlIdle);
        check_cnt("in_reset_instret", 0);
        check("in_reset_illegal", 32'(bus.illegal_instr), 0);

        reset = 1'b1;
        #1;
        check_ctl("s_reset_ctl", CtlIdle);
        tick();
        drive(OpR, 1'b0, 1'b0);
        check_ctl("fetch_wait", CtlFetch);
        check_cnt("fetch_instret0", 0);
        tick();
        drive(OpR, 1'b0, 1'b0);
        check_ctl("fetch_hold", CtlFetch);

        // add
        start(OpR);
        check_ctl("exec_r", CtlExecR);
        tick();
        drive(OpR, 1'b0, 1'b1);
        check_ctl("aluwb_r", CtlAluWb);
        tick();
        drive(OpR, 1'b0, 1'b0);
        check_ctl("fetch_after_add", CtlFetch);
        check_cnt("instret_add", 1);

        // lw with three stalled cycles in MEMREAD
        start(OpLoad);
        check_ctl("memadr_lw", CtlMemAdr);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(OpLoad, 1'b0, 1'b0);
            check_ctl("memread_stall", CtlMemRead);
        end
        tick();
        drive(OpLoad, 1'b0, 1'b1);
        check_ctl("memread_ready", CtlMemRead);
        tick();
        drive(OpLoad, 1'b0, 1'b0);
        check_ctl("memwb", CtlMemWb);
        tick();
        drive(OpLoad, 1'b0, 1'b0);
        check_ctl("fetch_after_lw", CtlFetch);
        check_cnt("instret_lw", 2);

        // beq taken
        start(OpB);
        drive(OpB, 1'b1, 1'b0);
        check_ctl("beq_taken", CtlBeqTaken);
        tick();
        drive(OpB, 1'b0, 1'b0);
        check_ctl("fetch_after_beq_t", CtlFetch);
        check_cnt("instret_beq_t", 3);

        // beq not taken
        start(OpB);
        check_ctl("beq_not_taken", CtlBeqNot);
        tick();
        drive(OpB, 1'b0, 1'b0);
        check_ctl("fetch_after_beq_n", CtlFetch);
        check_cnt("instret_beq_n", 4);

        // jal
        start(OpJ);
        check_ctl("jal", CtlJal);
        tick();
        drive(OpJ, 1'b0, 1'b0);
        check_ctl("aluwb_jal", CtlAluWb);
        tick();
        drive(OpJ, 1'b0, 1'b0);
        check_ctl("fetch_after_jal", CtlFetch);
        check_cnt("instret_jal", 5);

        // sw with one stall
        start(OpS);
        check_ctl("memadr_sw", CtlMemAdr);
        tick();
        drive(OpS, 1'b0, 1'b0);
        check_ctl("memwrite_stall", CtlMemWrite);
        tick();
        drive(OpS, 1'b0, 1'b1);
        check_ctl("memwrite_ready", CtlMemWrite);
        tick();
        drive(OpS, 1'b0, 1'b0);
        check_ctl("fetch_after_sw", CtlFetch);
        check_cnt("instret_sw", 6);

        // sw interrupted by reset while in MEMWRITE
        start(OpS);
        tick();
        drive(OpS, 1'b0, 1'b0);
        check_ctl("memwrite_pre_reset", CtlMemWrite);
        reset = 1'b0;
        #1;
        check_ctl("reset_in_memwrite", CtlIdle);
        check_cnt("reset_in_memwrite_cnt", 0);
        tick();
        tick();
        reset = 1'b1;
        drive(OpI, 1'b0, 1'b0);
        check_ctl("s_reset_again", CtlIdle);
        tick();
        drive(OpI, 1'b0, 1'b0);
        check_ctl("fetch_after_reset", CtlFetch);
        check_cnt("instret_after_reset", 0);

        // 16 addi: counter wraps back to zero
        for (int i = 0; i < 16; i++) begin
            start(OpI);
            check_ctl("exec_i", CtlExecI);
            tick();
            drive(OpI, 1'b0, 1'b0);
            check_ctl("aluwb_i", CtlAluWb);
            tick();
            drive(OpI, 1'b0, 1'b0);
            check_cnt("instret_wrap", (i + 1) & 15);
        end

        // unsupported opcode traps until reset
        check("illegal_before_trap", 32'(bus.illegal_instr), 0);
        start(OpBad);
        check_ctl("trap_ctl", CtlIdle);
        check("trap_illegal", 32'(bus.illegal_instr), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            drive(OpR, 1'b0, i[0]);
            check_ctl("trap_hold_ctl", CtlIdle);
            check("trap_hold_illegal", 32'(bus.illegal_instr), 1);
        end
        check_cnt("trap_instret", 0);
        reset = 1'b0;
        #1;
        check("illegal_cleared", 32'(bus.illegal_instr), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
